// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared size/state encodings and lane count for the data-memory access unit
package dmem_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/dmem_load_align.sv
// rtl/dmem_load_align.sv - moves the addressed byte/halfword to bit 0 and sign- or zero-extends it
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  assign shifted = word_i >> {lane_i, 3'b000};

  // Word accesses are only legal at lane 0, so the shifted word equals the raw word there.
  always_comb begin
    data_o = '0;
    case (size_e'(size_i))
      SZ_BYTE: data_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
      SZ_HALF: data_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
      SZ_WORD: data_o = shifted;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - byte/half/word data memory with valid/ready requests and fixed-latency responses
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 64,
  parameter int READ_LAT = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWE,
  input  logic [1:0]        ReqSize,
  input  logic              ReqSigned,
  input  logic [ADDR_W-1:0] ReqAdr,
  input  logic [DATA_W-1:0] ReqWD,
  output logic              RspValid,
  output logic [DATA_W-1:0] RspRD,
  output logic              RspErr
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_e            state_q;
  logic [2:0]        cnt_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rd_q;
  logic              err_q;

  logic              accept;
  logic              lane_err;
  logic              oor;
  logic              err;
  logic [ADDR_W-3:0] word_idx;
  logic [IDX_W-1:0]  idx;
  logic [LANES-1:0]  be;
  logic [DATA_W-1:0] wd_rep;
  logic [DATA_W-1:0] load_val;

  assign ReqReady = (state_q == ST_IDLE) && !Reset;
  assign accept   = ReqValid && ReqReady;
  assign word_idx = ReqAdr[ADDR_W-1:2];
  assign idx      = word_idx[IDX_W-1:0];
  assign oor      = word_idx >= (ADDR_W-2)'(DEPTH);
  assign err      = lane_err || oor;

  // Store data is replicated across lanes so each enabled lane picks its slice directly.
  always_comb begin
    be       = '0;
    wd_rep   = ReqWD;
    lane_err = 1'b0;
    case (size_e'(ReqSize))
      SZ_BYTE: begin
        be     = 4'b0001 << ReqAdr[1:0];
        wd_rep = {4{ReqWD[7:0]}};
      end
      SZ_HALF: begin
        be       = ReqAdr[1] ? 4'b1100 : 4'b0011;
        wd_rep   = {2{ReqWD[15:0]}};
        lane_err = ReqAdr[0];
      end
      SZ_WORD: begin
        be       = 4'b1111;
        lane_err = |ReqAdr[1:0];
      end
      default: lane_err = 1'b1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (accept && ReqWE && !err) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wd_rep[8*i +: 8];
      end
    end
  end

  dmem_load_align u_align (
    .word_i   (mem_q[idx]),
    .lane_i   (ReqAdr[1:0]),
    .size_i   (ReqSize),
    .signed_i (ReqSigned),
    .data_o   (load_val)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rd_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          rsp_valid_q <= 1'b0;
          if (accept) begin
            rd_q  <= (err || ReqWE) ? '0 : load_val;
            err_q <= err;
            if (READ_LAT == 0) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= 3'(READ_LAT - 1);
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 3'd0) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ST_RESP: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // A reset landing on the response cycle still swallows the pulse.
  assign RspValid = rsp_valid_q && !Reset;
  assign RspRD    = rd_q;
  assign RspErr   = err_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb/tb_dmem_access_unit.sv - directed table-driven bench for dmem_access_unit
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_valid_b;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_adr, req_wd;

  logic        a_ready, a_rsp_valid, a_err;
  logic [31:0] a_rd;
  logic        b_ready, b_rsp_valid, b_err;
  logic [31:0] b_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_access_unit #(.READ_LAT(3)) dut_a (
    .Clk(clk), .Reset(rst), .ReqValid(req_valid), .ReqReady(a_ready),
    .ReqWE(req_we), .ReqSize(req_size), .ReqSigned(req_signed),
    .ReqAdr(req_adr), .ReqWD(req_wd),
    .RspValid(a_rsp_valid), .RspRD(a_rd), .RspErr(a_err)
  );

  dmem_access_unit #(.READ_LAT(0)) dut_b (
    .Clk(clk), .Reset(rst), .ReqValid(req_valid_b), .ReqReady(b_ready),
    .ReqWE(req_we), .ReqSize(req_size), .ReqSigned(req_signed),
    .ReqAdr(req_adr), .ReqWD(req_wd),
    .RspValid(b_rsp_valid), .RspRD(b_rd), .RspErr(b_err)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  vec_t bb[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] adr, input logic [31:0] wd,
                              input logic [31:0] exp_rd, input logic exp_err);
    vec_t v;
    v.we = we; v.size = size; v.sgn = sgn; v.adr = adr; v.wd = wd;
    v.exp_rd = exp_rd; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    req_we = v.we; req_size = v.size; req_signed = v.sgn; req_adr = v.adr; req_wd = v.wd;
  endtask

  task automatic do_req(input vec_t v, output logic [31:0] rd, output logic err, output int lat);
    int n;
    @(negedge clk);
    drive(v);
    req_valid = 1'b1;
    n = 0;
    while (!a_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!a_rsp_valid && lat < 50) begin @(negedge clk); lat++; end
    rd  = a_rd;
    err = a_err;
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat, nrsp, idx, cyc;
    logic        acc;

    rst = 1'b1; req_valid = 1'b0; req_valid_b = 1'b0;
    req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0; req_adr = '0; req_wd = '0;

    vecs.push_back(mk(1, 2'b10, 0, 32'h08, 32'h11223344, 32'h0,        0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h09, 32'h0,        32'h00000033, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h0B, 32'h0,        32'h00000011, 0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h0A, 32'h0,        32'h00001122, 0));
    vecs.push_back(mk(1, 2'b00, 1, 32'h0A, 32'h12345680, 32'h0,        0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h08, 32'h0,        32'h11803344, 0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h0A, 32'h0,        32'hFFFFFF80, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h0A, 32'h0,        32'h00000080, 0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h0A, 32'h0,        32'h00001180, 0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h05, 32'h0,        32'h0,        1));
    vecs.push_back(mk(0, 2'b10, 0, 32'h06, 32'h0,        32'h0,        1));
    vecs.push_back(mk(0, 2'b11, 0, 32'h08, 32'h0,        32'h0,        1));
    vecs.push_back(mk(1, 2'b10, 0, 32'h100, 32'hCAFEF00D, 32'h0,       1));
    vecs.push_back(mk(1, 2'b10, 0, 32'h0A, 32'hFFFFFFFF, 32'h0,        1));
    vecs.push_back(mk(0, 2'b10, 0, 32'h08, 32'h0,        32'h11803344, 0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h0C, 32'h55667788, 32'h0,        0));
    vecs.push_back(mk(1, 2'b01, 0, 32'h0E, 32'hABCDF234, 32'h0,        0));
    vecs.push_back(mk(0, 2'b10, 1, 32'h0C, 32'h0,        32'hF2347788, 0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h0E, 32'h0,        32'hFFFFF234, 0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h0E, 32'h0,        32'h0000F234, 0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h0C, 32'h0,        32'h00007788, 0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h0D, 32'h0,        32'h00000077, 0));
    vecs.push_back(mk(1, 2'b10, 0, 32'hFC, 32'h0BADBEEF, 32'h0,        0));
    vecs.push_back(mk(0, 2'b10, 0, 32'hFC, 32'h0,        32'h0BADBEEF, 0));

    bb[0] = mk(1, 2'b10, 0, 32'h20, 32'hA5A5A5A5, 32'h0,        0);
    bb[1] = mk(0, 2'b10, 0, 32'h20, 32'h0,        32'hA5A5A5A5, 0);
    bb[2] = mk(0, 2'b00, 1, 32'h21, 32'h0,        32'hFFFFFFA5, 0);
    bb[3] = mk(0, 2'b01, 0, 32'h03, 32'h0,        32'h0,        1);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready_a", a_ready, 0);
    check("rst_ready_b", b_ready, 0);
    check("rst_rspvalid", a_rsp_valid, 0);
    check("rst_rd", a_rd, 0);
    check("rst_err", a_err, 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", a_ready, 1);

    // Table of accesses on the READ_LAT=3 instance
    for (int i = 0; i < vecs.size(); i++) begin
      do_req(vecs[i], rd, err, lat);
      check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
      check($sformatf("vec%0d_lat", i), lat, 4);
    end

    // Cycle-exact latency, READ_LAT=3
    @(negedge clk);
    drive(mk(0, 2'b10, 0, 32'h08, 32'h0, 32'h0, 0));
    req_valid = 1'b1;
    check("lat3_c0_ready", a_ready, 1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      check($sformatf("lat3_c%0d_rspvalid", c), a_rsp_valid, (c == 4));
      check($sformatf("lat3_c%0d_ready", c), a_ready, (c == 5));
      if (c == 4) check("lat3_rd", a_rd, 32'h11803344);
    end

    // Cycle-exact latency, READ_LAT=0
    @(negedge clk);
    drive(mk(0, 2'b10, 0, 32'h08, 32'h0, 32'h0, 0));
    req_valid_b = 1'b1;
    check("lat0_c0_ready", b_ready, 1);
    check("lat0_c0_rspvalid", b_rsp_valid, 0);
    @(negedge clk);
    req_valid_b = 1'b0;
    check("lat0_c1_rspvalid", b_rsp_valid, 1);
    check("lat0_c1_err", b_err, 0);
    @(negedge clk);
    check("lat0_c2_rspvalid", b_rsp_valid, 0);
    check("lat0_c2_ready", b_ready, 1);

    // Reset while a store is waiting for its response
    @(negedge clk);
    drive(mk(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0));
    req_valid = 1'b1;
    check("rstmid_c0_ready", a_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    check("rstmid_c1_rspvalid", a_rsp_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstmid_c2_ready", a_ready, 0);
    check("rstmid_c2_rspvalid", a_rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmid_c3_ready", a_ready, 1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("rstmid_quiet%0d", c), a_rsp_valid, 0);
    end
    do_req(mk(0, 2'b10, 0, 32'h10, 32'h0, 32'h0, 0), rd, err, lat);
    check("rstmid_commit_rd", rd, 32'hDEADBEEF);
    check("rstmid_commit_err", err, 0);

    // Back-to-back requests with ReqValid held high
    @(negedge clk);
    idx = 0;
    nrsp = 0;
    drive(bb[0]);
    req_valid = 1'b1;
    for (cyc = 0; cyc < 60; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (a_rsp_valid) begin
        if (nrsp < 4) begin
          check($sformatf("bb%0d_rd", nrsp), a_rd, bb[nrsp].exp_rd);
          check($sformatf("bb%0d_err", nrsp), a_err, bb[nrsp].exp_err);
        end
        nrsp++;
      end
      acc = a_ready && req_valid;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 4) drive(bb[idx]);
        else req_valid = 1'b0;
      end
    end
    check("bb_count", nrsp, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
